// File: rtl/ula_control_if.sv
// rtl/ula_control_if.sv - ALU-control decode bus between main control and the ALU
interface ula_control_if;
    logic [0:1] OpALU;
    logic [0:5] funct;
    logic [0:3] inputALU;
    logic       illegal_funct;

    modport master (
        output OpALU,
        output funct,
        input  inputALU,
        input  illegal_funct
    );

    modport slave (
        input  OpALU,
        input  funct,
        output inputALU,
        output illegal_funct
    );
endinterface

// File: rtl/ula_control.sv
// rtl/ula_control.sv - registered MIPS ALU-control decoder (OpALU + funct -> ALU select)
module ula_control (
    input  logic           clk,
    input  logic           rst_n,
    ula_control_if.slave   bus
);
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    logic [3:0] sel_d;
    logic       illegal_d;

    always_comb begin
        sel_d     = ALU_ADD;
        illegal_d = 1'b0;
        case (bus.OpALU)
            2'b00: sel_d = ALU_ADD;
            2'b01: sel_d = ALU_SUB;
            2'b10: begin
                // Unsupported R-type codes still produce ADD so the datapath stays well defined.
                case (bus.funct)
                    6'b100000: sel_d = ALU_ADD;
                    6'b100001: sel_d = ALU_ADD;
                    6'b100010: sel_d = ALU_SUB;
                    6'b100011: sel_d = ALU_SUB;
                    6'b100100: sel_d = ALU_AND;
                    6'b100101: sel_d = ALU_OR;
                    6'b100111: sel_d = ALU_NOR;
                    6'b101010: sel_d = ALU_SLT;
                    default: begin
                        sel_d     = ALU_ADD;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            default: sel_d = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.inputALU      <= ALU_ADD;
            bus.illegal_funct <= 1'b0;
        end else begin
            bus.inputALU      <= sel_d;
            bus.illegal_funct <= illegal_d;
        end
    end
endmodule

// File: tb/tb_ula_control.sv
// tb/tb_ula_control.sv - scoreboard bench for ula_control with directed and random vectors
module tb_ula_control;
    typedef struct packed {
        logic [3:0] alu;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ula_control_if bus ();

    ula_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    logic [5:0] legal_fn  [8] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                  6'b100100, 6'b100101, 6'b100111, 6'b101010};
    logic [3:0] legal_alu [8] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110,
                                  4'b0000, 4'b0001, 4'b1100, 4'b0111};

    function automatic exp_t model(input logic rstn, input logic [1:0] op, input logic [5:0] fn);
        exp_t r;
        r.alu = 4'b0010;
        r.ill = 1'b0;
        if (rstn && op == 2'b01) r.alu = 4'b0110;
        if (rstn && op == 2'b10) begin
            r.ill = 1'b1;
            for (int i = 0; i < 8; i++)
                if (legal_fn[i] == fn) begin
                    r.alu = legal_alu[i];
                    r.ill = 1'b0;
                end
        end
        return r;
    endfunction

    task automatic step(input logic rstn, input logic [1:0] op, input logic [5:0] fn, input int n);
        repeat (n) begin
            rst_n     = rstn;
            bus.OpALU = op;
            bus.funct = fn;
            @(posedge clk);
            #1;
            q.push_back(model(rstn, op, fn));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (bus.inputALU !== e.alu || bus.illegal_funct !== e.ill) begin
                miscompares++;
                $display("FAIL decode t=%0t: got inputALU=%b illegal_funct=%b, expected inputALU=%b illegal_funct=%b",
                         $time, bus.inputALU, bus.illegal_funct, e.alu, e.ill);
            end
        end
    end

    initial begin
        logic [1:0] op;
        logic [5:0] fn;
        logic       rn;

        step(1'b0, 2'b10, 6'b100100, 2);
        step(1'b1, 2'b10, 6'b100100, 1);

        step(1'b1, 2'b00, 6'b000000, 1);
        step(1'b1, 2'b01, 6'b000000, 1);
        step(1'b1, 2'b11, 6'b101010, 1);

        for (int i = 0; i < 8; i++) step(1'b1, 2'b10, legal_fn[i], 2);

        step(1'b1, 2'b10, 6'b000000, 1);
        step(1'b1, 2'b10, 6'b111111, 1);
        step(1'b1, 2'b00, 6'b000000, 1);
        step(1'b1, 2'b00, 6'b111111, 1);

        step(1'b1, 2'b10, 6'b100100, 1);
        step(1'b1, 2'b10, 6'b100101, 1);
        step(1'b1, 2'b10, 6'b100100, 1);
        step(1'b0, 2'b10, 6'b100101, 1);
        step(1'b1, 2'b10, 6'b100101, 1);
        step(1'b1, 2'b10, 6'b100100, 1);

        for (int i = 0; i < 400; i++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) fn = legal_fn[$urandom_range(0, 7)];
            else                           fn = 6'($urandom);
            rn = ($urandom_range(0, 15) != 0);
            step(rn, op, fn, 1);
        end

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
